// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES host interface
package aes_pkg;
    typedef enum logic [1:0] {OP_NONE, OP_LOAD_KEY, OP_ENC, OP_DEC} aes_op_t;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} host_state_t;
    localparam int WORDS_PER_BLOCK = 4;
    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);
endpackage

// File: rtl/aes_word_shift.sv
// aes_word_shift: 128-bit register, parallel load or shift by one 32-bit word, most significant word first
module aes_word_shift (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] load_data,
    input  logic         shift,
    input  logic [31:0]  shift_in,
    output logic [127:0] nxt,
    output logic [31:0]  word
);
    logic [127:0] q;
    assign nxt  = {q[95:0], shift_in};
    assign word = q[127:96];
    // parallel load wins over a shift in the same cycle
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else if (load) q <= load_data;
        else if (shift) q <= nxt;
endmodule

// File: rtl/aes_host_if.sv
// aes_host_if: host-side command/word front end driving the AES-128 core start/done interface
module aes_host_if
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [127:0] core_key,
    output logic [127:0] core_data,
    output logic         core_start,
    output logic         core_key_change,
    output logic         core_sel_cypher,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic         key_valid,
    output logic         err_no_key,
    output logic         err_timeout
);
    host_state_t      state, state_nxt;
    aes_op_t          op;
    logic [1:0]       cnt;
    logic [CNT_W-1:0] wd;
    logic             key_pending;
    logic             cmd_fire, in_fire, out_fire, cmd_ok, last_word, wd_expired;
    logic [127:0]     in_nxt, unused_out_nxt;
    logic [31:0]      unused_in_word;

    assign cmd_fire   = cmd_valid & (state == IDLE);
    assign in_fire    = in_valid & (state == LOAD);
    assign out_fire   = out_ready & (state == UNLOAD);
    assign cmd_ok     = (cmd_op == OP_LOAD_KEY) | (cmd_op[1] & key_valid);
    assign last_word  = cnt == LAST_WORD;
    assign wd_expired = wd == CNT_W'(TIMEOUT_CYCLES - 1);

    aes_word_shift u_in (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_fire),
        .shift_in  (in_data),
        .nxt       (in_nxt),
        .word      (unused_in_word)
    );

    aes_word_shift u_out (
        .clk       (clk),
        .reset     (reset),
        .load      ((state == WAIT) & core_done),
        .load_data (core_result),
        .shift     (out_fire),
        .shift_in  ('0),
        .nxt       (unused_out_nxt),
        .word      (out_data)
    );

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    // next state; a done arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_ok) state_nxt = LOAD;
            LOAD:    if (in_fire && last_word) state_nxt = (op == OP_LOAD_KEY) ? IDLE : START;
            START:   state_nxt = WAIT;
            WAIT:    if (core_done) state_nxt = UNLOAD;
                     else if (wd_expired) state_nxt = IDLE;
            UNLOAD:  if (out_fire && last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake, core strobes and error pulses decoded from state
    always_comb begin
        cmd_ready       = state == IDLE;
        in_ready        = state == LOAD;
        out_valid       = state == UNLOAD;
        core_start      = state == START;
        core_key_change = (state == START) & key_pending;
        core_sel_cypher = (state == START) & ~op[0];
        err_no_key      = cmd_fire & ~cmd_ok;
        err_timeout     = (state == WAIT) & ~core_done & wd_expired;
    end

    // operation, word counter, watchdog and the key/data registers seen by the core
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            op          <= OP_NONE;
            cnt         <= '0;
            wd          <= '0;
            key_valid   <= 1'b0;
            key_pending <= 1'b0;
            core_key    <= '0;
            core_data   <= '0;
        end else begin
            if (cmd_fire && cmd_ok) op <= aes_op_t'(cmd_op);
            if (in_fire || out_fire) cnt <= cnt + 2'd1;
            wd <= (state == WAIT) ? wd + 1'b1 : '0;
            if (state == START) key_pending <= 1'b0;
            if (in_fire && last_word) begin
                if (op == OP_LOAD_KEY) begin
                    core_key    <= in_nxt;
                    key_valid   <= 1'b1;
                    key_pending <= 1'b1;
                end else begin
                    core_data <= in_nxt;
                end
            end
        end
endmodule

// File: tb/tb_aes_host_if.sv
// tb_aes_host_if: directed scenarios for the AES host front end against a table-driven core model
module tb_aes_host_if;
    import aes_pkg::*;
    localparam int TO = 64;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BAD = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    logic clk, reset, cmd_valid, cmd_ready, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] cmd_op;
    logic [31:0] in_data, out_data;
    logic [127:0] core_key, core_data, core_result, model_r;
    logic core_start, core_key_change, core_sel_cypher, core_done, key_valid, err_no_key, err_timeout;
    int n_cmp = 0, n_bad = 0;
    bit hang = 0;

    aes_host_if #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_key(core_key), .core_data(core_data), .core_start(core_start),
        .core_key_change(core_key_change), .core_sel_cypher(core_sel_cypher),
        .core_done(core_done), .core_result(core_result),
        .key_valid(key_valid), .err_no_key(err_no_key), .err_timeout(err_timeout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // core model: answers the FIPS-197 example vectors five cycles after a start, unless hung
    initial begin
        core_done = 0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && !hang) begin
                if (core_sel_cypher) model_r = (core_key == KEY && core_data == PT) ? CT : BAD;
                else model_r = (core_key == KEY && core_data == CT) ? PT : BAD;
                repeat (5) @(posedge clk);
                #1 core_done = 1; core_result = model_r;
                @(posedge clk);
                #1 core_done = 0; core_result = '0;
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op);
        int i = 0;
        cmd_op = op; cmd_valid = 1;
        while (cmd_ready !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        if (i == 50) begin n_cmp++; n_bad++; $display("FAIL cmd_accept: cmd_ready=%b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int i = 0;
        in_data = w; in_valid = 1;
        while (in_ready !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        if (i == 50) begin n_cmp++; n_bad++; $display("FAIL in_accept: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic recv_word(input int hold, output logic [31:0] w, output bit stable);
        int i = 0;
        logic [31:0] first;
        stable = 1;
        while (out_valid !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        if (i == 50) begin n_cmp++; n_bad++; $display("FAIL out_wait: out_valid=%b want 1", out_valid); end
        first = out_data;
        repeat (hold) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== first) stable = 0;
        end
        out_ready = 1; w = out_data;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic run_block(input logic [1:0] op, input logic [127:0] blk, input bit gaps, input int hold_w,
                             output logic [127:0] res, output logic kc, output logic sc,
                             output logic start_ok, output logic in_ok, output logic done_ok, output bit stable);
        int i = 0;
        logic [31:0] w;
        bit st;
        send_cmd(op);
        in_ok = in_ready;
        for (int j = 0; j < 4; j++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(blk[127-32*j -: 32]);
        end
        start_ok = core_start; kc = core_key_change; sc = core_sel_cypher;
        res = '0; done_ok = 0; stable = 1;
        if (op != OP_LOAD_KEY) begin
            while (core_done !== 1'b1 && i < 100) begin @(negedge clk); i++; end
            if (i == 100) begin n_cmp++; n_bad++; $display("FAIL done_wait: core_done=%b want 1", core_done); end
            @(negedge clk);
            done_ok = out_valid;
            for (int j = 0; j < 4; j++) begin
                recv_word(j == hold_w ? 10 : 0, w, st);
                res[127-32*j -: 32] = w;
                stable &= st;
            end
        end
    endtask

    task automatic test_reset;
        reset = 0; cmd_valid = 0; cmd_op = 0; in_valid = 0; in_data = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({key_valid, in_ready, out_valid, core_start, core_key_change, core_sel_cypher, err_no_key, err_timeout} !== 8'h0) begin n_bad++; $display("FAIL rst_flags: got %b want 0", {key_valid, in_ready, out_valid, core_start, core_key_change, core_sel_cypher, err_no_key, err_timeout}); end
        n_cmp++; if (core_key !== '0) begin n_bad++; $display("FAIL rst_key: got %h want 0", core_key); end
        n_cmp++; if (core_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", core_data); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out: got %h want 0", out_data); end
        reset = 1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_no_key;
        foreach (cmd_op[i]) ;
        for (int k = 0; k < 2; k++) begin
            cmd_op = (k == 0) ? OP_ENC : OP_NONE; cmd_valid = 1;
            #1;
            n_cmp++; if (err_no_key !== 1'b1) begin n_bad++; $display("FAIL nokey_pulse%0d: got %b want 1", k, err_no_key); end
            @(negedge clk);
            cmd_valid = 0;
            #1;
            n_cmp++; if ({err_no_key, in_ready, cmd_ready} !== 3'b001) begin n_bad++; $display("FAIL nokey_after%0d: got %b want 001", k, {err_no_key, in_ready, cmd_ready}); end
            @(negedge clk);
        end
    endtask

    task automatic test_encrypt;
        logic [127:0] res;
        logic kc, sc, so, io, dn;
        bit st;
        run_block(OP_LOAD_KEY, KEY, 0, -1, res, kc, sc, so, io, dn, st);
        n_cmp++; if ({key_valid, cmd_ready, so, io} !== 4'b1101) begin n_bad++; $display("FAIL load_key: got %b want 1101", {key_valid, cmd_ready, so, io}); end
        n_cmp++; if (core_key !== KEY) begin n_bad++; $display("FAIL core_key: got %h want %h", core_key, KEY); end
        run_block(OP_ENC, PT, 0, -1, res, kc, sc, so, io, dn, st);
        n_cmp++; if ({io, so, kc, sc, dn} !== 5'b11111) begin n_bad++; $display("FAIL enc_ctrl: got %b want 11111", {io, so, kc, sc, dn}); end
        n_cmp++; if (res !== CT) begin n_bad++; $display("FAIL enc_result: got %h want %h", res, CT); end
        n_cmp++; if (core_data !== PT) begin n_bad++; $display("FAIL enc_core_data: got %h want %h", core_data, PT); end
    endtask

    task automatic test_decrypt;
        logic [127:0] res;
        logic kc, sc, so, io, dn;
        bit st;
        run_block(OP_DEC, CT, 0, -1, res, kc, sc, so, io, dn, st);
        n_cmp++; if ({so, kc, sc, dn} !== 4'b1001) begin n_bad++; $display("FAIL dec_ctrl: got %b want 1001", {so, kc, sc, dn}); end
        n_cmp++; if (res !== PT) begin n_bad++; $display("FAIL dec_result: got %h want %h", res, PT); end
        n_cmp++; if (core_key !== KEY) begin n_bad++; $display("FAIL dec_key_held: got %h want %h", core_key, KEY); end
    endtask

    task automatic test_timeout;
        logic [127:0] res;
        logic kc, sc, so, io, dn;
        bit st;
        int k = 0;
        hang = 1;
        send_cmd(OP_ENC);
        for (int j = 0; j < 4; j++) send_word(PT[127-32*j -: 32]);
        n_cmp++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL to_start: got %b want 1", core_start); end
        for (int c = 1; c <= TO + 16; c++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin k = c; break; end
        end
        n_cmp++; if (k !== TO) begin n_bad++; $display("FAIL to_cycles: got %0d want %0d", k, TO); end
        @(negedge clk);
        n_cmp++; if ({err_timeout, cmd_ready, key_valid, out_valid} !== 4'b0110) begin n_bad++; $display("FAIL to_after: got %b want 0110", {err_timeout, cmd_ready, key_valid, out_valid}); end
        hang = 0;
        run_block(OP_ENC, PT, 0, -1, res, kc, sc, so, io, dn, st);
        n_cmp++; if (res !== CT || kc !== 1'b0) begin n_bad++; $display("FAIL to_retry: got %h kc=%b want %h kc=0", res, kc, CT); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] res;
        logic kc, sc, so, io, dn;
        bit st;
        run_block(OP_ENC, PT, 1, 1, res, kc, sc, so, io, dn, st);
        n_cmp++; if (res !== CT) begin n_bad++; $display("FAIL bp_enc_result: got %h want %h", res, CT); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL bp_stable: got %b want 1", st); end
        run_block(OP_DEC, CT, 1, 3, res, kc, sc, so, io, dn, st);
        n_cmp++; if (res !== PT || st !== 1'b1) begin n_bad++; $display("FAIL bp_dec: got %h st=%b want %h st=1", res, st, PT); end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        send_cmd(OP_ENC);
        for (int j = 0; j < 4; j++) send_word(PT[127-32*j -: 32]);
        n_cmp++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL rm_start: got %b want 1", core_start); end
        repeat (2) @(negedge clk);
        #2 reset = 0;
        #1;
        n_cmp++; if ({key_valid, out_valid, in_ready, core_start} !== 4'b0) begin n_bad++; $display("FAIL rm_flags: got %b want 0000", {key_valid, out_valid, in_ready, core_start}); end
        n_cmp++; if (core_key !== '0 || core_data !== '0) begin n_bad++; $display("FAIL rm_regs: got %h %h want 0 0", core_key, core_data); end
        @(negedge clk);
        reset = 1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rm_late_done: out_valid seen=%b want 0", seen); end
        cmd_op = OP_ENC; cmd_valid = 1;
        #1;
        n_cmp++; if (err_no_key !== 1'b1) begin n_bad++; $display("FAIL rm_key_lost: err_no_key=%b want 1", err_no_key); end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    initial begin
        test_reset;
        test_no_key;
        test_encrypt;
        test_decrypt;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
